// File: rtl/fp_pkg.sv
// Shared types and constants for the sequential floating-point multiplier.
// Format helpers are functions of EXP_W/MAN_W so any width can reuse them.
package fp_pkg;

  localparam int FP_EXP_W = 5;
  localparam int FP_MAN_W = 10;

  localparam int FLG_NX = 0;
  localparam int FLG_UF = 1;
  localparam int FLG_OF = 2;
  localparam int FLG_NV = 3;

  typedef enum logic [2:0] {
    IDLE,
    MUL,
    NORM,
    RND,
    DONE
  } state_t;

  function automatic int fp_bias(input int ew);
    return (1 << (ew - 1)) - 1;
  endfunction

  function automatic logic [63:0] fp_qnan(input int ew, input int mw);
    logic [63:0] v;
    v = ((64'd1 << ew) - 64'd1) << mw;
    v = v | (64'd1 << (mw - 1));
    return v;
  endfunction

endpackage

// File: rtl/fp_lzc.sv
// Leading-zero counter used to normalise the raw significand product.
// An all-zero input reports WIDTH.
module fp_lzc #(
  parameter int WIDTH = 22,
  parameter int CW    = $clog2(WIDTH + 1)
) (
  input  logic [WIDTH-1:0] i_d,
  output logic [CW-1:0]    o_cnt
);

  logic w_found;

  always_comb begin
    o_cnt   = CW'(WIDTH);
    w_found = 1'b0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (!w_found && i_d[i]) begin
        o_cnt   = CW'(WIDTH - 1 - i);
        w_found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fp_mpy_seq.sv
// Multi-cycle IEEE-style multiplier with valid/ready ports, radix-2 shift-add.
// Define FP_MPY_FLAGS_EN to add the flags[3:0] = {nv, of, uf, nx} output.
module fp_mpy_seq
  import fp_pkg::*;
#(
  parameter int EXP_W = FP_EXP_W,
  parameter int MAN_W = FP_MAN_W
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [EXP_W+MAN_W:0]   in_a,
  input  logic [EXP_W+MAN_W:0]   in_b,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [EXP_W+MAN_W:0]   out_p
`ifdef FP_MPY_FLAGS_EN
  ,
  output logic [3:0]             flags
`endif
);

  localparam int W    = 1 + EXP_W + MAN_W;
  localparam int N    = MAN_W + 1;
  localparam int P    = 2 * N;
  localparam int EW2  = EXP_W + 2;
  localparam int CW   = $clog2(N + 1);
  localparam int LW   = $clog2(P + 1);
  localparam int EMAX = (1 << EXP_W) - 1;

  localparam logic [EW2-1:0] BIAS = EW2'(fp_bias(EXP_W));
  localparam logic [W-1:0]   QNAN = W'(fp_qnan(EXP_W, MAN_W));

  state_t r_state, w_nxt;

  logic [CW-1:0]         r_cnt;
  logic [N-1:0]          r_mcand;
  logic [P-1:0]          r_prod;
  logic signed [EW2-1:0] r_exp;
  logic                  r_sign;
  logic                  r_spc;
  logic [W-1:0]          r_spc_val;
  logic [P-2:0]          r_man;
  logic                  r_stk;
  logic [W-1:0]          r_out;

  logic [EXP_W-1:0] w_ea, w_eb;
  logic [MAN_W-1:0] w_fa, w_fb;
  logic             w_ha, w_hb, w_sgn;
  logic             w_infa, w_infb;
  logic             w_nana, w_nanb;
  logic             w_zera, w_zerb;
  logic             w_nan;
  logic [EW2-1:0]   w_ex;
  logic             w_spc;
  logic [W-1:0]     w_spc_val;

  assign w_ea  = in_a[W-2:MAN_W];
  assign w_eb  = in_b[W-2:MAN_W];
  assign w_fa  = in_a[MAN_W-1:0];
  assign w_fb  = in_b[MAN_W-1:0];
  assign w_ha  = |w_ea;
  assign w_hb  = |w_eb;
  assign w_sgn = in_a[W-1] ^ in_b[W-1];

  assign w_infa = (&w_ea) & ~(|w_fa);
  assign w_infb = (&w_eb) & ~(|w_fb);
  assign w_nana = (&w_ea) & (|w_fa);
  assign w_nanb = (&w_eb) & (|w_fb);
  assign w_zera = ~w_ha & ~(|w_fa);
  assign w_zerb = ~w_hb & ~(|w_fb);
  assign w_nan  = w_nana | w_nanb
                | (w_infa & w_zerb)
                | (w_zera & w_infb);

  // Subnormals use an effective exponent of 1.
  assign w_ex = EW2'(w_ha ? w_ea : EXP_W'(1))
              + EW2'(w_hb ? w_eb : EXP_W'(1))
              - BIAS;

  always_comb begin
    w_spc     = 1'b1;
    w_spc_val = QNAN;
    if (w_nan) begin
      w_spc_val = QNAN;
    end else if (w_infa | w_infb) begin
      w_spc_val = {w_sgn, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    end else if (w_zera | w_zerb) begin
      w_spc_val = {w_sgn, {(W-1){1'b0}}};
    end else begin
      w_spc = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_nxt;
  end

  always_comb begin
    w_nxt     = r_state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (r_state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) w_nxt = MUL;
      end
      MUL:  if (r_cnt == CW'(N - 1)) w_nxt = NORM;
      NORM: w_nxt = RND;
      RND:  w_nxt = DONE;
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) w_nxt = IDLE;
      end
      default: w_nxt = IDLE;
    endcase
  end

  logic [N:0] w_add;

  assign w_add = {1'b0, r_prod[P-1:N]}
               + (r_prod[0] ? {1'b0, r_mcand} : '0);

  logic [LW-1:0] w_lz;

  fp_lzc #(
    .WIDTH (P)
  ) u_lzc (
    .i_d   (r_prod),
    .o_cnt (w_lz)
  );

  logic [P-1:0] w_m;
  logic         w_st;
  int           w_ei;
  int           w_sh;
  int           w_rs;

  // Hidden bit lands at P-2; tiny results are denormalised to exp 1.
  always_comb begin
    w_m  = r_prod;
    w_st = 1'b0;
    w_ei = int'(r_exp);
    w_sh = 0;
    w_rs = 0;
    if (r_prod[P-1]) begin
      w_m  = r_prod >> 1;
      w_st = r_prod[0];
      w_ei = w_ei + 1;
    end else if (w_ei > 1) begin
      w_sh = int'(w_lz) - 1;
      if (w_sh > w_ei - 1) w_sh = w_ei - 1;
    end
    w_m  = w_m << w_sh;
    w_ei = w_ei - w_sh;
    if (w_ei < 1) begin
      w_rs = 1 - w_ei;
      w_st = w_st | (|(w_m & ~({P{1'b1}} << w_rs)));
      w_m  = w_m >> w_rs;
      w_ei = 1;
    end
  end

  logic [N-1:0] w_kept;
  logic [N-1:0] w_mf;
  logic [N:0]   w_rsum;
  logic         w_g, w_r, w_s;
  logic         w_up, w_co;
  int           w_ef;
  logic [W-1:0] w_res;

  assign w_kept = r_man[P-2:MAN_W];
  assign w_g    = r_man[MAN_W-1];
  assign w_r    = r_man[MAN_W-2];
  assign w_s    = (|r_man[MAN_W-3:0]) | r_stk;
  assign w_up   = w_g & (w_r | w_s | w_kept[0]);
  assign w_rsum = {1'b0, w_kept} + {{N{1'b0}}, w_up};
  assign w_co   = w_rsum[N];
  assign w_mf   = w_co ? w_rsum[N:1] : w_rsum[N-1:0];

  always_comb begin
    w_ef  = int'(r_exp) + (w_co ? 1 : 0);
    w_res = '0;
    if (r_spc) begin
      w_res = r_spc_val;
    end else if (!w_mf[N-1]) begin
      w_res = {r_sign, {EXP_W{1'b0}}, w_mf[MAN_W-1:0]};
    end else if (w_ef >= EMAX) begin
      w_res = {r_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    end else begin
      w_res = {r_sign, w_ef[EXP_W-1:0], w_mf[MAN_W-1:0]};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt     <= '0;
      r_mcand   <= '0;
      r_prod    <= '0;
      r_exp     <= '0;
      r_sign    <= 1'b0;
      r_spc     <= 1'b0;
      r_spc_val <= '0;
      r_man     <= '0;
      r_stk     <= 1'b0;
      r_out     <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_cnt     <= '0;
            r_mcand   <= {w_ha, w_fa};
            r_prod    <= {{N{1'b0}}, w_hb, w_fb};
            r_exp     <= w_ex;
            r_sign    <= w_sgn;
            r_spc     <= w_spc;
            r_spc_val <= w_spc_val;
          end
        end
        MUL: begin
          r_prod <= {w_add, r_prod[N-1:1]};
          r_cnt  <= r_cnt + CW'(1);
        end
        NORM: begin
          r_man <= w_m[P-2:0];
          r_stk <= w_st;
          r_exp <= EW2'(w_ei);
        end
        RND:     r_out <= w_res;
        default: ;
      endcase
    end
  end

  assign out_p = r_out;

`ifdef FP_MPY_FLAGS_EN
  logic       r_inv;
  logic       r_tiny;
  logic [3:0] r_flg;
  logic       w_inv, w_of, w_nx;
  logic [3:0] w_flg;

  // Only signalling NaNs and inf*0 raise invalid.
  assign w_inv = (w_infa & w_zerb) | (w_zera & w_infb)
               | (w_nana & ~w_fa[MAN_W-1])
               | (w_nanb & ~w_fb[MAN_W-1]);
  assign w_of  = w_mf[N-1] && (w_ef >= EMAX);
  assign w_nx  = w_g | w_r | w_s | w_of;

  always_comb begin
    w_flg = '0;
    if (r_spc) begin
      w_flg[FLG_NV] = r_inv;
    end else begin
      w_flg[FLG_OF] = w_of;
      w_flg[FLG_NX] = w_nx;
      w_flg[FLG_UF] = r_tiny & w_nx;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_inv  <= 1'b0;
      r_tiny <= 1'b0;
      r_flg  <= '0;
    end else begin
      if (r_state == IDLE && in_valid) r_inv <= w_inv;
      if (r_state == NORM) r_tiny <= (w_rs > 0);
      if (r_state == RND) r_flg <= w_flg;
    end
  end

  assign flags = r_flg;
`endif

endmodule

// File: tb/tb_fp_mpy_seq.sv
// Directed bench for fp_mpy_seq: FP16 default instance plus an FP32 instance.
// Covers products, subnormals, specials, backpressure and reset abort.
module tb_fp_mpy_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_a = '0;
  logic [15:0] in_b = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [15:0] out_p;

  logic        in_valid32 = 1'b0;
  logic        in_ready32;
  logic [31:0] in_a32 = '0;
  logic [31:0] in_b32 = '0;
  logic        out_valid32;
  logic        out_ready32 = 1'b1;
  logic [31:0] out_p32;

`ifdef FP_MPY_FLAGS_EN
  logic [3:0] flags;
  logic [3:0] flags32;
  logic [3:0] last_flags = '0;
`endif

  int total = 0;
  int bad   = 0;

  localparam logic [15:0] SUB_A [3] = '{16'h0FCC, 16'hA06D, 16'h2C52};
  localparam logic [15:0] SUB_B [3] = '{16'h8ADB, 16'h89AB, 16'hE687};
  localparam logic [15:0] SUB_P [3] = '{16'h8002, 16'h0019, 16'hD70D};

  localparam logic [15:0] SPC_A [4] = '{16'h7C00, 16'h7BFF, 16'h8000, 16'h7E01};
  localparam logic [15:0] SPC_B [4] = '{16'h0000, 16'h7BFF, 16'h3C00, 16'h3C00};
  localparam logic [15:0] SPC_P [4] = '{16'h7E00, 16'h7C00, 16'h8000, 16'h7E00};

  always #5 clk = ~clk;

  fp_mpy_seq u_dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_p     (out_p)
`ifdef FP_MPY_FLAGS_EN
    ,
    .flags     (flags)
`endif
  );

  fp_mpy_seq #(
    .EXP_W (8),
    .MAN_W (23)
  ) u_dut32 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid32),
    .in_ready  (in_ready32),
    .in_a      (in_a32),
    .in_b      (in_b32),
    .out_valid (out_valid32),
    .out_ready (out_ready32),
    .out_p     (out_p32)
`ifdef FP_MPY_FLAGS_EN
    ,
    .flags     (flags32)
`endif
  );

  task automatic do_op(input logic [15:0] a, input logic [15:0] b,
                       output logic [15:0] p, output int lat);
    @(negedge clk);
    in_a = a;
    in_b = b;
    in_valid = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    lat = 0;
    while (out_valid !== 1'b1 && lat < 60) begin
      @(posedge clk);
      #1;
      lat++;
    end
    p = out_p;
`ifdef FP_MPY_FLAGS_EN
    last_flags = flags;
`endif
    if (out_valid !== 1'b1) lat = -1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (in_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_in_ready got %b want 1", in_ready);
    end
    total++;
    if (out_valid !== 1'b0) begin
      bad++;
      $display("FAIL reset_out_valid got %b want 0", out_valid);
    end
    total++;
    if (out_p !== 16'h0000) begin
      bad++;
      $display("FAIL reset_out_p got %h want 0000", out_p);
    end
    total++;
    if (in_ready32 !== 1'b1 || out_valid32 !== 1'b0 || out_p32 !== 32'h0) begin
      bad++;
      $display("FAIL reset_fp32 got rdy=%b vld=%b p=%h want 1 0 0",
               in_ready32, out_valid32, out_p32);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_basic();
    logic [15:0] p;
    int lat;
    do_op(16'hBB67, 16'hF5CB, p, lat);
    total++;
    if (p !== 16'h755C) begin
      bad++;
      $display("FAIL basic0 got %h want 755C", p);
    end
    total++;
    if (lat !== 13) begin
      bad++;
      $display("FAIL basic0_lat got %0d want 13", lat);
    end
    do_op(16'h6DA0, 16'hAB89, p, lat);
    total++;
    if (p !== 16'hDD4C) begin
      bad++;
      $display("FAIL basic1 got %h want DD4C", p);
    end
    total++;
    if (lat !== 13) begin
      bad++;
      $display("FAIL basic1_lat got %0d want 13", lat);
    end
  endtask

  task automatic test_subnormal();
    logic [15:0] p;
    int lat;
    for (int i = 0; i < 3; i++) begin
      do_op(SUB_A[i], SUB_B[i], p, lat);
      total++;
      if (p !== SUB_P[i]) begin
        bad++;
        $display("FAIL sub%0d %h*%h got %h want %h",
                 i, SUB_A[i], SUB_B[i], p, SUB_P[i]);
      end
      total++;
      if (lat !== 13) begin
        bad++;
        $display("FAIL sub%0d_lat got %0d want 13", i, lat);
      end
    end
  endtask

  task automatic test_specials();
    logic [15:0] p;
    int lat;
    for (int i = 0; i < 4; i++) begin
      do_op(SPC_A[i], SPC_B[i], p, lat);
      total++;
      if (p !== SPC_P[i]) begin
        bad++;
        $display("FAIL spc%0d %h*%h got %h want %h",
                 i, SPC_A[i], SPC_B[i], p, SPC_P[i]);
      end
      total++;
      if (lat !== 13) begin
        bad++;
        $display("FAIL spc%0d_lat got %0d want 13", i, lat);
      end
`ifdef FP_MPY_FLAGS_EN
      if (i == 1) begin
        total++;
        if (last_flags[2] !== 1'b1) begin
          bad++;
          $display("FAIL spc_overflow_flag got %b want 1", last_flags[2]);
        end
      end
`endif
    end
  endtask

  task automatic test_backpressure();
    int n;
    @(negedge clk);
    in_a = 16'h6DA0;
    in_b = 16'hAB89;
    in_valid = 1'b1;
    out_ready = 1'b0;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    n = 0;
    while (out_valid !== 1'b1 && n < 60) begin
      @(posedge clk);
      #1;
      n++;
    end
    total++;
    if (n !== 13) begin
      bad++;
      $display("FAIL bp_lat got %0d want 13", n);
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      in_a = 16'h3C00;
      in_b = 16'h3C00;
      in_valid = (i % 2 == 0);
      @(posedge clk);
      #1;
      total++;
      if (out_valid !== 1'b1 || out_p !== 16'hDD4C || in_ready !== 1'b0) begin
        bad++;
        $display("FAIL bp_hold%0d got vld=%b p=%h rdy=%b want 1 DD4C 0",
                 i, out_valid, out_p, in_ready);
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      bad++;
      $display("FAIL bp_release got vld=%b rdy=%b want 0 1", out_valid, in_ready);
    end
    n = 0;
    repeat (20) begin
      @(posedge clk);
      #1;
      if (out_valid === 1'b1) n++;
    end
    total++;
    if (n !== 0) begin
      bad++;
      $display("FAIL bp_no_capture got %0d extra valid cycles want 0", n);
    end
  endtask

  task automatic test_reset_mid();
    logic [15:0] p;
    int lat;
    int n;
    @(negedge clk);
    in_a = 16'h3C00;
    in_b = 16'h4000;
    in_valid = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_p !== 16'h0000) begin
      bad++;
      $display("FAIL rst_mid got vld=%b rdy=%b p=%h want 0 1 0000",
               out_valid, in_ready, out_p);
    end
    @(negedge clk);
    rst = 1'b0;
    n = 0;
    repeat (16) begin
      @(posedge clk);
      #1;
      if (out_valid === 1'b1) n++;
    end
    total++;
    if (n !== 0) begin
      bad++;
      $display("FAIL rst_abort got %0d valid cycles want 0", n);
    end
    do_op(16'h0FCC, 16'h8ADB, p, lat);
    total++;
    if (p !== 16'h8002 || lat !== 13) begin
      bad++;
      $display("FAIL rst_after got p=%h lat=%0d want 8002 13", p, lat);
    end
  endtask

  task automatic test_fp32();
    int n;
    @(negedge clk);
    in_a32 = 32'h3F800000;
    in_b32 = 32'h40490FDB;
    in_valid32 = 1'b1;
    out_ready32 = 1'b1;
    @(posedge clk);
    #1;
    in_valid32 = 1'b0;
    n = 0;
    while (out_valid32 !== 1'b1 && n < 80) begin
      @(posedge clk);
      #1;
      n++;
    end
    total++;
    if (n !== 26) begin
      bad++;
      $display("FAIL fp32_lat got %0d want 26", n);
    end
    total++;
    if (out_p32 !== 32'h40490FDB) begin
      bad++;
      $display("FAIL fp32_p got %h want 40490FDB", out_p32);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_subnormal();
    test_specials();
    test_backpressure();
    test_reset_mid();
    test_fp32();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
